// File: rtl/gf180mcu_osu_sc_gp9t3v3__mon_pkg.sv
`default_nettype none
// ============================================================================
// Module : gf180mcu_osu_sc_gp9t3v3__mon_pkg
// Purpose: Shared definitions for the buffer-chain delay monitor.
//          Holds the FSM state encoding and the legal synchronizer depth
//          range, with a helper that keeps a requested depth inside it.
// Ports  : (package, none)
// Rev    : 1.0  initial release
// ============================================================================
package gf180mcu_osu_sc_gp9t3v3__mon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2,
    ST_REPORT = 2'd3
  } mon_state_t;

  localparam int SYNC_STAGES_MIN = 2;
  localparam int SYNC_STAGES_MAX = 4;

  // Out-of-range depths are pulled to the nearest legal value so the
  // synchronizer is never built with fewer than two flops.
  function automatic int sync_stages_clamp(input int n);
    if (n < SYNC_STAGES_MIN) return SYNC_STAGES_MIN;
    if (n > SYNC_STAGES_MAX) return SYNC_STAGES_MAX;
    return n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/gf180mcu_osu_sc_gp9t3v3__sync_n.sv
`default_nettype none
// ============================================================================
// Module : gf180mcu_osu_sc_gp9t3v3__sync_n
// Purpose: N-flop synchronizer for a single asynchronous level.
// Ports  : clk  - sampling clock
//          rst  - asynchronous active-high reset, clears every stage
//          d    - asynchronous input level
//          q    - synchronized level (STAGES clk edges of latency)
// Rev    : 1.0  initial release
// ============================================================================
module gf180mcu_osu_sc_gp9t3v3__sync_n
  import gf180mcu_osu_sc_gp9t3v3__mon_pkg::*;
#(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  localparam int N = sync_stages_clamp(STAGES);

  logic [N-1:0] ff;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ff <= '0;
    end else begin
      ff <= {ff[N-2:0], d};
    end
  end

  assign q = ff[N-1];

endmodule
`default_nettype wire

// File: rtl/gf180mcu_osu_sc_gp9t3v3__bufchain_mon.sv
`default_nettype none
// ============================================================================
// Module : gf180mcu_osu_sc_gp9t3v3__bufchain_mon
// Purpose: Measures the round-trip delay of an external buffer chain in CLK
//          cycles. Each measurement toggles LAUNCH once and counts cycles
//          until the synchronized ECHO matches the new LAUNCH level, or
//          gives up at MAX_CYC.
// Ports  : CLK     - clock, rising edge
//          R       - asynchronous active-high reset
//          START   - request a measurement (only honoured in IDLE)
//          ECHO    - far end of the chain, asynchronous to CLK
//          LAUNCH  - level driven into the chain
//          BUSY    - high whenever the FSM is not IDLE
//          DONE    - one-cycle pulse when COUNT/TIMEOUT are updated
//          COUNT   - measured delay in CLK cycles
//          TIMEOUT - last measurement ran out without an echo
// Rev    : 1.0  initial release
// ============================================================================
module gf180mcu_osu_sc_gp9t3v3__bufchain_mon
  import gf180mcu_osu_sc_gp9t3v3__mon_pkg::*;
#(
  parameter int CNT_W       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int MAX_CYC     = 255
) (
  input  logic             CLK,
  input  logic             R,
  input  logic             START,
  input  logic             ECHO,
  output logic             LAUNCH,
  output logic             BUSY,
  output logic             DONE,
  output logic [CNT_W-1:0] COUNT,
  output logic             TIMEOUT
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_CYC);

  mon_state_t       state, state_next;
  logic [CNT_W-1:0] counter, counter_next;
  logic [CNT_W-1:0] count_q, count_next;
  logic             launch_q, launch_next;
  logic             timeout_q, timeout_next;
  logic             sync_echo;

  gf180mcu_osu_sc_gp9t3v3__sync_n #(
    .STAGES(SYNC_STAGES)
  ) u_echo_sync (
    .clk(CLK),
    .rst(R),
    .d  (ECHO),
    .q  (sync_echo)
  );

  always_ff @(posedge CLK or posedge R) begin
    if (R) begin
      state     <= ST_IDLE;
      counter   <= '0;
      count_q   <= '0;
      launch_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state     <= state_next;
      counter   <= counter_next;
      count_q   <= count_next;
      launch_q  <= launch_next;
      timeout_q <= timeout_next;
    end
  end

  always_comb begin
    state_next   = state;
    counter_next = counter;
    count_next   = count_q;
    launch_next  = launch_q;
    timeout_next = timeout_q;
    case (state)
      ST_IDLE: begin
        if (START) state_next = ST_LAUNCH;
      end
      ST_LAUNCH: begin
        launch_next  = ~launch_q;
        counter_next = '0;
        state_next   = ST_WAIT;
      end
      ST_WAIT: begin
        // The echo check comes first so a match on the last allowed cycle
        // is still reported as a valid measurement, not a timeout.
        if (sync_echo == launch_q) begin
          count_next   = counter;
          timeout_next = 1'b0;
          state_next   = ST_REPORT;
        end else if (counter == MAX_CNT) begin
          count_next   = MAX_CNT;
          timeout_next = 1'b1;
          state_next   = ST_REPORT;
        end else begin
          counter_next = counter + 1'b1;
        end
      end
      ST_REPORT: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Status outputs decode the state register only, so nothing from an
  // input reaches an output without passing through a flop.
  assign BUSY    = (state != ST_IDLE);
  assign DONE    = (state == ST_REPORT);
  assign LAUNCH  = launch_q;
  assign COUNT   = count_q;
  assign TIMEOUT = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_gf180mcu_osu_sc_gp9t3v3__bufchain_mon.sv
`default_nettype none
// ============================================================================
// Module : tb_gf180mcu_osu_sc_gp9t3v3__bufchain_mon
// Purpose: Self-checking bench for the buffer-chain delay monitor. ECHO is
//          produced from LAUNCH through a selectable clocked delay line, or
//          tied to a constant level.
// Rev    : 1.0  initial release
// ============================================================================
module tb_gf180mcu_osu_sc_gp9t3v3__bufchain_mon;

  logic       clk = 1'b0;
  logic       r;
  logic       start;
  logic       echo;
  logic       launch;
  logic       busy;
  logic       done;
  logic [7:0] count;
  logic       timeout;

  logic [255:0] dly = '0;
  int           dsel;
  logic         stuck;
  logic         stuck_val;

  int n_tests;
  int n_fail;

  always #5 clk = ~clk;

  // dly[d-1] holds the LAUNCH level from d edges ago.
  always @(posedge clk) dly <= {dly[254:0], launch};
  assign echo = stuck ? stuck_val : ((dsel == 0) ? launch : dly[dsel - 1]);

  gf180mcu_osu_sc_gp9t3v3__bufchain_mon #(
    .CNT_W      (8),
    .SYNC_STAGES(2),
    .MAX_CYC    (255)
  ) dut (
    .CLK    (clk),
    .R      (r),
    .START  (start),
    .ECHO   (echo),
    .LAUNCH (launch),
    .BUSY   (busy),
    .DONE   (done),
    .COUNT  (count),
    .TIMEOUT(timeout)
  );

  typedef struct {
    int   delay;
    logic stuck;
    int   exp_count;
    logic exp_to;
    logic exp_launch;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d", name, act, exp);
    end
  endtask

  // Pulse START for one edge, then follow the measurement until DONE.
  // lat  : edges from the START-sampling edge to the first DONE sample
  // bcyc : samples with BUSY high, starting at the START-sampling edge
  task automatic run_meas(output int lat, output int bcyc, output logic ok);
    lat  = 0;
    bcyc = 0;
    ok   = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    if (busy) bcyc++;
    for (int k = 1; k <= 400; k++) begin
      @(posedge clk);
      #1;
      if (busy) bcyc++;
      if (done) begin
        lat = k;
        ok  = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   lat;
    int   bcyc;
    logic ok;
    int   ndone;
    int   t[4];
    logic l[4];

    n_tests = 0;
    n_fail  = 0;

    //            delay stuck  count  to     launch-after
    vecs[0] = '{  0,    1'b0,  2,     1'b0,  1'b1};  // loopback, rising
    vecs[1] = '{  5,    1'b0,  7,     1'b0,  1'b0};  // delayed, falling
    vecs[2] = '{  5,    1'b0,  7,     1'b0,  1'b1};  // delayed, rising
    vecs[3] = '{  253,  1'b0,  255,   1'b0,  1'b0};  // match exactly at limit
    vecs[4] = '{  0,    1'b1,  255,   1'b1,  1'b1};  // stuck low, rising
    vecs[5] = '{  254,  1'b0,  255,   1'b1,  1'b0};  // one cycle past limit
    vecs[6] = '{  1,    1'b0,  3,     1'b0,  1'b1};  // short delay
    vecs[7] = '{  0,    1'b1,  0,     1'b0,  1'b0};  // stuck low, falling: instant match

    r         = 1'b1;
    start     = 1'b0;
    stuck     = 1'b0;
    stuck_val = 1'b0;
    dsel      = 0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_launch",  launch,  0);
    check("rst_busy",    busy,    0);
    check("rst_done",    done,    0);
    check("rst_count",   count,   0);
    check("rst_timeout", timeout, 0);
    @(negedge clk);
    r = 1'b0;

    for (int i = 0; i < 8; i++) begin
      dsel      = vecs[i].delay;
      stuck     = vecs[i].stuck;
      stuck_val = 1'b0;
      repeat (vecs[i].delay + 4) @(posedge clk);
      run_meas(lat, bcyc, ok);
      check($sformatf("v%0d_done_seen", i), ok, 1);
      check($sformatf("v%0d_count", i), count, vecs[i].exp_count);
      check($sformatf("v%0d_timeout", i), timeout, vecs[i].exp_to);
      check($sformatf("v%0d_launch", i), launch, vecs[i].exp_launch);
      check($sformatf("v%0d_latency", i), lat, vecs[i].exp_count + 2);
      check($sformatf("v%0d_busy_cycles", i), bcyc, vecs[i].exp_count + 3);
      @(posedge clk);
      #1;
      check($sformatf("v%0d_idle_busy", i), busy, 0);
      check($sformatf("v%0d_done_width", i), done, 0);
      check($sformatf("v%0d_count_hold", i), count, vecs[i].exp_count);
    end

    // START pulsed during WAIT and during REPORT must not add a measurement.
    dsel  = 5;
    stuck = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    ndone = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      if (k == 3 || k == 4) start = 1'b1;
      if (done) begin
        ndone++;
        start = 1'b1;
        if (ndone == 1) check("startwait_count", count, 7);
      end
    end
    start = 1'b0;
    check("startwait_ndone", ndone, 1);
    check("startwait_idle", busy, 0);

    // START held high: back-to-back loopback runs every 6 cycles.
    dsel = 0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    start = 1'b1;
    ndone = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        if (ndone < 4) begin
          t[ndone] = k;
          l[ndone] = launch;
          check($sformatf("held_count%0d", ndone), count, 2);
        end
        ndone++;
      end
    end
    check("held_enough_dones", (ndone >= 4), 1);
    for (int i = 1; i < 4; i++) begin
      check($sformatf("held_period%0d", i), t[i] - t[i-1], 6);
      check($sformatf("held_alternate%0d", i), l[i] ^ l[i-1], 1);
    end
    @(negedge clk);
    start = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    check("held_release_idle", ok, 1);

    // Reset in the middle of WAIT with counter at 10.
    stuck     = 1'b1;
    stuck_val = launch;
    repeat (4) @(posedge clk);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (11) @(posedge clk);
    #1;
    check("midwait_busy_before", busy, 1);
    r = 1'b1;
    #1;
    check("midrst_launch",  launch,  0);
    check("midrst_busy",    busy,    0);
    check("midrst_done",    done,    0);
    check("midrst_count",   count,   0);
    check("midrst_timeout", timeout, 0);
    @(negedge clk);
    r = 1'b0;
    ndone = 0;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk);
      #1;
      if (done) ndone++;
    end
    check("midrst_no_done", ndone, 0);

    stuck = 1'b0;
    dsel  = 0;
    repeat (4) @(posedge clk);
    run_meas(lat, bcyc, ok);
    check("postrst_done_seen", ok, 1);
    check("postrst_count", count, 2);
    check("postrst_timeout", timeout, 0);
    check("postrst_launch", launch, 1);
    check("postrst_latency", lat, 4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
